// File: rtl/phase_scheduler_pkg.sv
// traffic_pkg: shared types and constants for the intersection phase scheduler.
//   state_t        - controller phase (all-red, green, yellow)
//   ap_t / AP_*    - approach indices: north-north, north-south, through
//   T_GREEN/T_YELLOW/T_ALLRED - phase lengths in ticks for timing tables A..D
//   ap_inc, ap_onehot, rr_pick - approach index helpers
package traffic_pkg;

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    typedef logic [1:0] ap_t;

    localparam ap_t AP_NN = 2'd0;
    localparam ap_t AP_NS = 2'd1;
    localparam ap_t AP_TH = 2'd2;

    // Index = TABLE_SEL (0=A, 1=B, 2=C, 3=D).
    localparam logic [7:0] T_GREEN  [4] = '{8'd17, 8'd25, 8'd10, 8'd40};
    localparam logic [7:0] T_YELLOW [4] = '{8'd3,  8'd3,  8'd3,  8'd4};
    localparam logic [7:0] T_ALLRED [4] = '{8'd2,  8'd2,  8'd1,  8'd2};

    // Next approach in the fixed rotation NN -> NS -> TH -> NN.
    function automatic ap_t ap_inc(input ap_t a);
        return (a == AP_TH) ? AP_NN : ap_t'(a + 2'd1);
    endfunction

    function automatic logic [2:0] ap_onehot(input ap_t a);
        return 3'b001 << a;
    endfunction

    // First requesting approach after cur in rotation order; falls back to
    // cur+1 when nothing is pending.
    function automatic ap_t rr_pick(input ap_t cur, input logic [2:0] pend);
        ap_t first;
        ap_t second;
        first  = ap_inc(cur);
        second = ap_inc(first);
        if (pend[first])
            return first;
        else if (pend[second])
            return second;
        else
            return first;
    endfunction

endpackage

// File: rtl/phase_scheduler_tick_prescaler.sv
// tick_prescaler: free-running divider producing the phase timing strobe.
//   CLK   - system clock
//   RST_N - asynchronous active-low reset
//   TICK  - high for the single cycle where the count equals TICK_DIV-1
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 48000000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic TICK
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign TICK = (count == LAST);

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler: sequences three approaches through green/yellow/all-red,
// serving latched vehicle and pedestrian demands in round-robin order.
//   CLK, RST_N        - clock, asynchronous active-low reset
//   SNN, SNS, STH     - vehicle sensors, approaches 0/1/2 (asynchronous)
//   PNN, PNS, PTH     - pedestrian buttons, approaches 0/1/2 (asynchronous)
//   TABLE_SEL         - timing table A..D, sampled on entry to green
//   GREEN, YELLOW     - one-hot lamp enables per approach
//   WALK              - pedestrian walk per approach (green phase only)
//   TIMER             - ticks remaining in the current phase
//   TICK              - one-cycle timing strobe
module phase_scheduler #(
    parameter int unsigned TICK_DIV = 48000000,
    parameter int unsigned TIMER_W  = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               SNN,
    input  logic               SNS,
    input  logic               STH,
    input  logic               PNN,
    input  logic               PNS,
    input  logic               PTH,
    input  logic [1:0]         TABLE_SEL,
    output logic [2:0]         GREEN,
    output logic [2:0]         YELLOW,
    output logic [2:0]         WALK,
    output logic [TIMER_W-1:0] TIMER,
    output logic               TICK
);

    import traffic_pkg::*;

    logic tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST_N(RST_N),
        .TICK (tick)
    );

    // Two-flop synchronisers for the asynchronous sensor and button inputs.
    logic [2:0] s_raw, s_meta, s_sync;
    logic [2:0] p_raw, p_meta, p_sync;

    assign s_raw = {STH, SNS, SNN};
    assign p_raw = {PTH, PNS, PNN};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_meta <= '0;
            s_sync <= '0;
            p_meta <= '0;
            p_sync <= '0;
        end else begin
            s_meta <= s_raw;
            s_sync <= s_meta;
            p_meta <= p_raw;
            p_sync <= p_meta;
        end
    end

    state_t             state, state_nx;
    ap_t                cur, cur_nx;
    ap_t                nxt, nxt_nx;
    logic [1:0]         tbl, tbl_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic               walk, walk_nx;
    logic [2:0]         veh_req, veh_nx;
    logic [2:0]         ped_req, ped_nx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_ALLRED;
            cur     <= AP_TH;
            nxt     <= AP_NN;
            tbl     <= 2'd0;
            timer   <= TIMER_W'(T_ALLRED[0]);
            walk    <= 1'b0;
            veh_req <= '0;
            ped_req <= '0;
        end else begin
            state   <= state_nx;
            cur     <= cur_nx;
            nxt     <= nxt_nx;
            tbl     <= tbl_nx;
            timer   <= timer_nx;
            walk    <= walk_nx;
            veh_req <= veh_nx;
            ped_req <= ped_nx;
        end
    end

    logic [2:0] cur_oh, nxt_oh, veh_set, ped_set, pend;

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        nxt_nx   = nxt;
        tbl_nx   = tbl;
        walk_nx  = walk;

        cur_oh = ap_onehot(cur);
        nxt_oh = ap_onehot(nxt);

        // The approach currently showing green ignores its own demands.
        veh_set = s_sync;
        ped_set = p_sync;
        if (state == S_GREEN) begin
            veh_set = s_sync & ~cur_oh;
            ped_set = p_sync & ~cur_oh;
        end
        veh_nx = veh_req | veh_set;
        ped_nx = ped_req | ped_set;

        // Demands on other approaches, including ones synchronised this cycle,
        // so a late arrival still takes part in the round-robin choice.
        pend = (veh_nx | ped_nx) & ~cur_oh;

        timer_nx = timer;
        if (tick && (timer != '0))
            timer_nx = timer - TIMER_W'(1);

        unique case (state)
            S_ALLRED: begin
                if (tick && (timer <= TIMER_W'(1))) begin
                    state_nx = S_GREEN;
                    cur_nx   = nxt;
                    tbl_nx   = TABLE_SEL;
                    timer_nx = TIMER_W'(T_GREEN[TABLE_SEL]);
                    walk_nx  = ped_req[nxt];
                    // Clearing on entry overrides any set arriving this cycle.
                    veh_nx   = veh_nx & ~nxt_oh;
                    ped_nx   = ped_nx & ~nxt_oh;
                end
            end
            S_GREEN: begin
                // With nothing pending elsewhere the timer runs down to 0 and
                // green rests there until a demand appears.
                if (tick && (timer <= TIMER_W'(1)) && (pend != '0)) begin
                    state_nx = S_YELLOW;
                    nxt_nx   = rr_pick(cur, pend);
                    timer_nx = TIMER_W'(T_YELLOW[tbl]);
                    walk_nx  = 1'b0;
                end
            end
            S_YELLOW: begin
                if (tick && (timer <= TIMER_W'(1))) begin
                    state_nx = S_ALLRED;
                    timer_nx = TIMER_W'(T_ALLRED[tbl]);
                end
            end
            default: begin
                state_nx = S_ALLRED;
            end
        endcase
    end

    // Lamps decode straight from state so reset blanks them asynchronously.
    assign GREEN  = (state == S_GREEN)          ? cur_oh : '0;
    assign YELLOW = (state == S_YELLOW)         ? cur_oh : '0;
    assign WALK   = (state == S_GREEN && walk)  ? cur_oh : '0;
    assign TIMER  = timer;
    assign TICK   = tick;

endmodule

// File: tb/tb_phase_scheduler.sv
module tb_phase_scheduler;

    localparam int unsigned D = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       SNN = 1'b0, SNS = 1'b0, STH = 1'b0;
    logic       PNN = 1'b0, PNS = 1'b0, PTH = 1'b0;
    logic [1:0] TABLE_SEL = 2'd0;
    logic [2:0] GREEN, YELLOW, WALK;
    logic [7:0] TIMER;
    logic       TICK;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    phase_scheduler #(
        .TICK_DIV(D),
        .TIMER_W (8)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SNN      (SNN),
        .SNS      (SNS),
        .STH      (STH),
        .PNN      (PNN),
        .PNS      (PNS),
        .PTH      (PTH),
        .TABLE_SEL(TABLE_SEL),
        .GREEN    (GREEN),
        .YELLOW   (YELLOW),
        .WALK     (WALK),
        .TIMER    (TIMER),
        .TICK     (TICK)
    );

    // ---------------- reference model ----------------
    int tg[4] = '{17, 25, 10, 40};
    int ty[4] = '{3, 3, 3, 4};
    int ta[4] = '{2, 2, 1, 2};

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] y;
        logic [2:0] w;
        logic [7:0] t;
        logic       k;
    } exp_t;

    exp_t exp_q[$];

    int       m_ph;      // 0 = all red, 1 = green, 2 = yellow
    int       m_cur, m_nxt, m_tbl, m_left, m_cnt;
    bit       m_walk;
    bit       m_veh[3];
    bit       m_ped[3];
    bit [2:0] m_s1, m_s2, m_p1, m_p2;

    task automatic model_reset();
        m_ph = 0; m_cur = 2; m_nxt = 0; m_tbl = 0; m_left = 2; m_cnt = 0;
        m_walk = 0;
        for (int i = 0; i < 3; i++) begin
            m_veh[i] = 0;
            m_ped[i] = 0;
        end
        m_s1 = '0; m_s2 = '0; m_p1 = '0; m_p2 = '0;
    endtask

    task automatic model_step();
        bit   tick;
        bit   other;
        bit   found;
        bit   pb[3];
        int   a;
        exp_t e;
        tick = (m_cnt == D - 1);
        for (int i = 0; i < 3; i++) pb[i] = m_ped[i];
        for (int i = 0; i < 3; i++) begin
            if (!(m_ph == 1 && m_cur == i)) begin
                if (m_s2[i]) m_veh[i] = 1;
                if (m_p2[i]) m_ped[i] = 1;
            end
        end
        other = 0;
        for (int i = 0; i < 3; i++)
            if (i != m_cur && (m_veh[i] || m_ped[i])) other = 1;
        if (tick) begin
            case (m_ph)
                0: begin
                    if (m_left == 1) begin
                        m_ph = 1; m_cur = m_nxt; m_tbl = int'(TABLE_SEL);
                        m_left = tg[m_tbl]; m_walk = pb[m_cur];
                        m_veh[m_cur] = 0; m_ped[m_cur] = 0;
                    end else m_left--;
                end
                1: begin
                    if (m_left <= 1 && other) begin
                        m_ph = 2;
                        m_nxt = (m_cur + 1) % 3;
                        found = 0;
                        for (int off = 1; off <= 2; off++) begin
                            a = (m_cur + off) % 3;
                            if (!found && (m_veh[a] || m_ped[a])) begin
                                m_nxt = a;
                                found = 1;
                            end
                        end
                        m_left = ty[m_tbl]; m_walk = 0;
                    end else if (m_left > 0) m_left--;
                end
                default: begin
                    if (m_left == 1) begin
                        m_ph = 0; m_left = ta[m_tbl];
                    end else m_left--;
                end
            endcase
        end
        m_s2 = m_s1; m_s1 = {STH, SNS, SNN};
        m_p2 = m_p1; m_p1 = {PTH, PNS, PNN};
        m_cnt = (m_cnt + 1) % D;
        e = '0;
        if (m_ph == 1) e.g[m_cur] = 1'b1;
        if (m_ph == 2) e.y[m_cur] = 1'b1;
        if (m_ph == 1 && m_walk) e.w[m_cur] = 1'b1;
        e.t = 8'(m_left);
        e.k = (m_cnt == D - 1);
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_N && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({GREEN, YELLOW, WALK, TIMER, TICK} !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got g=%b y=%b w=%b timer=%0d tick=%b want g=%b y=%b w=%b timer=%0d tick=%b",
                             $time, GREEN, YELLOW, WALK, TIMER, TICK, e.g, e.y, e.w, e.t, e.k);
                end
                total++;
                if ($countones({GREEN, YELLOW}) > 1) begin
                    bad++;
                    $display("FAIL exclusive t=%0t got g=%b y=%b want at most one lamp", $time, GREEN, YELLOW);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_lamps(input string name, input logic [2:0] g, input logic [2:0] y, input int budget);
        int n = 0;
        while (!(GREEN == g && YELLOW == y) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (!(GREEN == g && YELLOW == y)) begin
            bad++;
            $display("FAIL %s timeout got g=%b y=%b want g=%b y=%b", name, GREEN, YELLOW, g, y);
        end
    endtask

    // mask bits: 0 SNN, 1 SNS, 2 STH, 3 PNN, 4 PNS, 5 PTH
    task automatic pulse(input logic [5:0] m, input int len);
        {PTH, PNS, PNN, STH, SNS, SNN} = m;
        cycles(len);
        {PTH, PNS, PNN, STH, SNS, SNN} = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        cycles(3);
        chk("reset_green", int'(GREEN), 0);
        chk("reset_yellow", int'(YELLOW), 0);
        chk("reset_walk", int'(WALK), 0);
        chk("reset_timer", int'(TIMER), 2);
        chk("reset_tick", int'(TICK), 0);
        RST_N = 1'b1;

        // start-up and rest in green
        wait_lamps("first_green", 3'b001, 3'b000, 60);
        chk("first_green_timer", int'(TIMER), 17);
        cycles(72);
        chk("rest_timer", int'(TIMER), 0);
        cycles(40);
        chk("rest_green", int'(GREEN), 3'b001);

        // demand during rest
        pulse(6'b000100, 3);
        wait_lamps("yellow_nn", 3'b000, 3'b001, 20);
        wait_lamps("green_th", 3'b100, 3'b000, 60);
        chk("green_th_timer", int'(TIMER), 17);

        // two simultaneous demands during green 0
        pulse(6'b000001, 3);
        wait_lamps("green_nn_again", 3'b001, 3'b000, 200);
        pulse(6'b000110, 3);
        wait_lamps("rr_first_ns", 3'b010, 3'b000, 200);
        wait_lamps("rr_second_th", 3'b100, 3'b000, 200);

        // pedestrian walk
        pulse(6'b000001, 3);
        wait_lamps("green_nn_ped", 3'b001, 3'b000, 200);
        pulse(6'b010000, 3);
        wait_lamps("green_ns_walk", 3'b010, 3'b000, 200);
        chk("walk_on", int'(WALK), 3'b010);
        pulse(6'b000001, 3);
        wait_lamps("yellow_ns", 3'b000, 3'b010, 200);
        chk("walk_off", int'(WALK), 0);

        // table switch mid-green
        wait_lamps("green_nn_tbl", 3'b001, 3'b000, 200);
        cycles(12);
        TABLE_SEL = 2'd3;
        pulse(6'b000100, 3);
        wait_lamps("green_th_d", 3'b100, 3'b000, 200);
        chk("table_d_timer", int'(TIMER), 40);
        pulse(6'b000001, 3);
        wait_lamps("yellow_th_d", 3'b000, 3'b100, 400);
        n = 0;
        while (YELLOW == 3'b100 && n < 100) begin
            cycles(1);
            n++;
        end
        chk("yellow_d_cycles", n, 16);
        TABLE_SEL = 2'd0;

        // asynchronous reset mid-yellow
        wait_lamps("green_nn_a", 3'b001, 3'b000, 100);
        chk("table_a_timer", int'(TIMER), 17);
        pulse(6'b000010, 3);
        wait_lamps("yellow_nn_rst", 3'b000, 3'b001, 200);
        cycles(5);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_green", int'(GREEN), 0);
        chk("rst_yellow", int'(YELLOW), 0);
        chk("rst_walk", int'(WALK), 0);
        chk("rst_timer", int'(TIMER), 2);
        cycles(2);
        RST_N = 1'b1;
        cycles(1);
        chk("post_rst_timer", int'(TIMER), 2);
        wait_lamps("post_rst_green", 3'b001, 3'b000, 40);

        // randomized demands and table changes
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) TABLE_SEL = 2'($urandom_range(0, 3));
            pulse(6'($urandom & $urandom), int'($urandom_range(2, 5)));
            cycles(int'($urandom_range(0, 40)));
        end

        cycles(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
